// File: rtl/cnt_msg_rx.sv
// cnt_msg_rx: UART 8N1 receiver plus a parser for "CNT: NN\r\n" report lines.
// Deserialised bytes feed a line parser that publishes a 6-bit count whenever
// a well-formed line carries a value of 63 or less.
module cnt_msg_rx #(
    parameter logic [31:0] CLOCK_FREQUENCY = 32'd27_000_000,
    parameter logic [31:0] BAUD_RATE       = 32'd115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [5:0] cnt,
    output logic       cnt_valid,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parse_err
);

    localparam logic [31:0] CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam logic [31:0] HALF         = CLKS_PER_BIT / 32'd2;
    localparam int          CW           = $clog2(CLKS_PER_BIT + 32'd1);

    localparam logic [7:0] CH_C     = 8'h43;
    localparam logic [7:0] CH_N     = 8'h4E;
    localparam logic [7:0] CH_T     = 8'h54;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
    } byte_state_e;

    typedef enum logic [3:0] {
        P_C, P_N, P_T, P_COL, P_SP, P_D1, P_D0, P_CR, P_LF
    } parse_state_e;

    // Synchroniser and edge-detect history
    logic rx_meta_q, rxs_q, rxs_prev_q;

    // Byte receiver state
    byte_state_e   byte_state_q, byte_state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;

    // Line parser state
    parse_state_e  parse_state_q, parse_state_d;
    logic [3:0]    d1_q, d1_d, d0_q, d0_d;
    logic [5:0]    cnt_q, cnt_d;
    logic          cnt_valid_q, cnt_valid_d;
    logic          parse_err_q, parse_err_d;
    logic          byte_ok;

    logic          tick_half, tick_bit, is_c, is_digit;
    logic [6:0]    line_value;

    assign tick_half  = (clk_cnt_q == CW'(HALF - 32'd1));
    assign tick_bit   = (clk_cnt_q == CW'(CLKS_PER_BIT - 32'd1));
    assign is_c       = (rx_byte_q == CH_C);
    assign is_digit   = (rx_byte_q >= 8'h30) && (rx_byte_q <= 8'h39);
    assign line_value = 7'(d1_q) * 7'd10 + 7'(d0_q);

    // Registers: synchroniser, byte receiver and parser, all cleared by rst.
    // Sync flops clear to 0 so a line already low at reset release shows no
    // falling edge.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            rx_meta_q     <= 1'b0;
            rxs_q         <= 1'b0;
            rxs_prev_q    <= 1'b0;
            byte_state_q  <= S_IDLE;
            clk_cnt_q     <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            rx_byte_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            parse_state_q <= P_C;
            d1_q          <= '0;
            d0_q          <= '0;
            cnt_q         <= '0;
            cnt_valid_q   <= 1'b0;
            parse_err_q   <= 1'b0;
        end else begin
            rx_meta_q     <= rx;
            rxs_q         <= rx_meta_q;
            rxs_prev_q    <= rxs_q;
            byte_state_q  <= byte_state_d;
            clk_cnt_q     <= clk_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            rx_byte_q     <= rx_byte_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            parse_state_q <= parse_state_d;
            d1_q          <= d1_d;
            d0_q          <= d0_d;
            cnt_q         <= cnt_d;
            cnt_valid_q   <= cnt_valid_d;
            parse_err_q   <= parse_err_d;
        end
    end

    // Byte receiver next state: start detect, mid-bit sampling, stop check.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        byte_state_d = byte_state_q;
        unique case (byte_state_q)
            S_IDLE:      if (rxs_prev_q && !rxs_q) byte_state_d = S_START;
            S_START:     if (tick_half) byte_state_d = rxs_q ? S_IDLE : S_DATA;
            S_DATA:      if (tick_bit && bit_idx_q == 3'd7) byte_state_d = S_STOP;
            S_STOP:      if (tick_bit) byte_state_d = rxs_q ? S_IDLE : S_WAIT_IDLE;
            S_WAIT_IDLE: if (rxs_q) byte_state_d = S_IDLE;
            default:     byte_state_d = S_IDLE;
        endcase
    end

    // Byte receiver datapath: bit timer, LSB-first shifter, byte/error pulses.
    always_comb begin
        clk_cnt_d   = clk_cnt_q + CW'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        unique case (byte_state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
            end
            S_START: if (tick_half) clk_cnt_d = '0;
            S_DATA: if (tick_bit) begin
                clk_cnt_d = '0;
                shift_d   = {rxs_q, shift_q[7:1]};
                bit_idx_d = bit_idx_q + 3'd1;
            end
            S_STOP: if (tick_bit) begin
                clk_cnt_d = '0;
                if (rxs_q) begin
                    rx_byte_d  = shift_q;
                    rx_valid_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            default: clk_cnt_d = '0;
        endcase
    end

    // Parser next state: walk the expected sequence; a stray 'C' resyncs.
    always_comb begin
        parse_state_d = parse_state_q;
        byte_ok       = 1'b0;
        unique case (parse_state_q)
            P_C:     byte_ok = is_c;
            P_N:     byte_ok = (rx_byte_q == CH_N);
            P_T:     byte_ok = (rx_byte_q == CH_T);
            P_COL:   byte_ok = (rx_byte_q == CH_COLON);
            P_SP:    byte_ok = (rx_byte_q == CH_SPACE);
            P_D1:    byte_ok = is_digit;
            P_D0:    byte_ok = is_digit;
            P_CR:    byte_ok = (rx_byte_q == CH_CR);
            P_LF:    byte_ok = (rx_byte_q == CH_LF);
            default: byte_ok = 1'b0;
        endcase
        if (frame_err_q) begin
            parse_state_d = P_C;
        end else if (rx_valid_q) begin
            if (!byte_ok) begin
                parse_state_d = is_c ? P_N : P_C;
            end else begin
                unique case (parse_state_q)
                    P_C:     parse_state_d = P_N;
                    P_N:     parse_state_d = P_T;
                    P_T:     parse_state_d = P_COL;
                    P_COL:   parse_state_d = P_SP;
                    P_SP:    parse_state_d = P_D1;
                    P_D1:    parse_state_d = P_D0;
                    P_D0:    parse_state_d = P_CR;
                    P_CR:    parse_state_d = P_LF;
                    default: parse_state_d = P_C;
                endcase
            end
        end
    end

    // Parser outputs: latch digits, publish count or flag syntax/range errors.
    always_comb begin
        d1_d        = d1_q;
        d0_d        = d0_q;
        cnt_d       = cnt_q;
        cnt_valid_d = 1'b0;
        parse_err_d = 1'b0;
        if (rx_valid_q) begin
            if (!byte_ok) begin
                // Noise between lines is dropped quietly while hunting for 'C'.
                parse_err_d = (parse_state_q != P_C);
            end else begin
                // ASCII digits 0x30..0x39 carry their value in the low nibble.
                if (parse_state_q == P_D1) d1_d = rx_byte_q[3:0];
                if (parse_state_q == P_D0) d0_d = rx_byte_q[3:0];
                if (parse_state_q == P_LF) begin
                    if (line_value <= 7'd63) begin
                        cnt_d       = line_value[5:0];
                        cnt_valid_d = 1'b1;
                    end else begin
                        parse_err_d = 1'b1;
                    end
                end
            end
        end
    end

    assign cnt       = cnt_q;
    assign cnt_valid = cnt_valid_q;
    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign parse_err = parse_err_q;

endmodule

// File: tb/tb_cnt_msg_rx.sv
// Directed bench for cnt_msg_rx: serial report lines, error cases, glitch and reset.
`timescale 1ns/1ps
module tb_cnt_msg_rx;

    // 1.6 MHz / 100 kbaud gives 16 clocks per bit, keeping the run short.
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [5:0] cnt;
    logic       cnt_valid;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;
    logic       parse_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse monitor state
    int         cyc = 0;
    int         n_rxv = 0, n_cv = 0, n_pe = 0, n_fe = 0, n_both = 0;
    int         last_rxv_cyc = 0, last_cv_cyc = 0;
    logic [7:0] last_byte = 8'h00;
    logic [5:0] cv_val [0:15];

    int b_rxv, b_cv, b_pe, b_fe;

    cnt_msg_rx #(
        .CLOCK_FREQUENCY(32'd1_600_000),
        .BAUD_RATE      (32'd100_000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .cnt      (cnt),
        .cnt_valid(cnt_valid),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .parse_err(parse_err)
    );

    always #5 clk = ~clk;

    // Count output pulses away from the active edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rx_valid) begin
            n_rxv        <= n_rxv + 1;
            last_byte    <= rx_byte;
            last_rxv_cyc <= cyc;
        end
        if (cnt_valid) begin
            n_cv              <= n_cv + 1;
            cv_val[n_cv[3:0]] <= cnt;
            last_cv_cyc       <= cyc;
        end
        if (parse_err) n_pe <= n_pe + 1;
        if (frame_err) n_fe <= n_fe + 1;
        if (cnt_valid && parse_err) n_both <= n_both + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Hold rx at v for one bit time; starts and ends 1 ns after a rising edge.
    task automatic hold(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        hold(1'b0);
        for (int i = 0; i < 8; i++) hold(b[i]);
        hold(stop_bit);
        rx = 1'b1;
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_rxv = n_rxv;
        b_cv  = n_cv;
        b_pe  = n_pe;
        b_fe  = n_fe;
    endtask

    task automatic check_deltas(input string tag, input int rxv, input int cv, input int pe, input int fe);
        check({tag, "_rx_valid_count"},  n_rxv - b_rxv, rxv);
        check({tag, "_cnt_valid_count"}, n_cv - b_cv, cv);
        check({tag, "_parse_err_count"}, n_pe - b_pe, pe);
        check({tag, "_frame_err_count"}, n_fe - b_fe, fe);
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cnt",       cnt, 0);
        check("reset_rx_byte",   rx_byte, 0);
        check("reset_pulses",    {rx_valid, cnt_valid, frame_err, parse_err}, 0);
        rst = 1'b0;
        repeat (2 * CPB) @(posedge clk);
        #1;

        // Plain line: nine bytes, one count update one cycle after the LF byte.
        snap();
        send_line("CNT: 42\r\n");
        settle();
        check_deltas("line42", 9, 1, 0, 0);
        check("line42_cnt",       cnt, 42);
        check("line42_last_byte", last_byte, 8'h0A);
        check("line42_rx_byte",   rx_byte, 8'h0A);
        check("line42_latency",   last_cv_cyc - last_rxv_cyc, 1);

        // Out-of-range value: error at LF, count unchanged.
        snap();
        send_line("CNT: 64\r\n");
        settle();
        check_deltas("line64", 9, 0, 1, 0);
        check("line64_cnt", cnt, 42);

        // Two lines back to back with no idle gap between frames.
        snap();
        send_line("CNT: 07\r\n");
        send_line("CNT: 63\r\n");
        settle();
        check_deltas("b2b", 18, 2, 0, 0);
        check("b2b_first_cnt",  cv_val[b_cv[3:0]], 7);
        check("b2b_second_cnt", cv_val[4'(b_cv + 1)], 63);
        check("b2b_cnt",        cnt, 63);

        // Bad byte after 'C' drops back to hunting for 'C'.
        snap();
        send_line("CXCNT: 05\r\n");
        settle();
        check_deltas("cx", 11, 1, 1, 0);
        check("cx_cnt", cnt, 5);

        // A second 'C' mid-line errors but resyncs straight into the new line.
        snap();
        send_line("CNCNT: 09\r\n");
        settle();
        check_deltas("cn", 11, 1, 1, 0);
        check("cn_cnt", cnt, 9);

        // Framing error mid-line: byte dropped, parser restarts at 'C' quietly.
        snap();
        send_line("CN");
        send_byte(8'h43, 1'b0);
        hold(1'b1);
        hold(1'b1);
        send_line("CNT: 11\r\n");
        settle();
        check_deltas("frame", 11, 1, 0, 1);
        check("frame_cnt", cnt, 11);

        // Low glitch shorter than half a bit is rejected at the start check.
        snap();
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        check_deltas("glitch", 0, 0, 0, 0);
        check("glitch_cnt", cnt, 11);

        // One-cycle reset in the middle of the data bits of 'T'.
        snap();
        send_line("CN");
        hold(1'b0);
        for (int i = 0; i < 3; i++) hold(CH_T_BIT(i));
        rx = 1'b0;
        repeat (CPB / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rx  = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        check_deltas("rstmid", 2, 0, 0, 0);
        check("rstmid_cnt",     cnt, 0);
        check("rstmid_rx_byte", rx_byte, 0);
        snap();
        send_line("CNT: 33\r\n");
        settle();
        check_deltas("after_rst", 9, 1, 0, 0);
        check("after_rst_cnt", cnt, 33);

        check("never_cnt_valid_and_parse_err", n_both, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Bits of 'T' (8'h54) for the partial frame before the reset.
    function automatic logic CH_T_BIT(input int i);
        logic [7:0] t;
        t = 8'h54;
        return t[i];
    endfunction

endmodule
